// File: rtl/sprite_draw_engine.sv
// Draws one W x H, 2-bit-per-pixel sprite from a synchronous ROM at a position latched once per frame.
// Two-clock pipeline: address + hit, then ROM read, then palette lookup into a registered pixel.
module sprite_draw_engine #(
  parameter int          W           = 78,
  parameter int          H           = 53,
  parameter int          SCALE_LOG2  = 0,
  parameter int          AW          = 13,
  parameter int          X_INIT      = 338,
  parameter int          Y_INIT      = 485,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter logic [7:0]  SHADE       = 8'hE0,
  parameter int          TRANSPARENT = 1
) (
  input  logic          vclk,
  input  logic          rst,
  input  logic [10:0]   hcount,
  input  logic [9:0]    vcount,
  input  logic          enable,
  input  logic [10:0]   x_pos,
  input  logic [9:0]    y_pos,
  input  logic [7:0]    fill_color,
  output logic [AW-1:0] rom_addr,
  input  logic [1:0]    rom_data,
  output logic [7:0]    pixel_out,
  output logic          pixel_valid
);

  localparam logic [11:0] SW_C = 12'(W << SCALE_LOG2);
  localparam logic [10:0] SH_C = 11'(H << SCALE_LOG2);
  localparam logic [11:0] HA_C = 12'(H_ACTIVE);
  localparam logic [10:0] VA_C = 11'(V_ACTIVE);

  logic [10:0]   r_x_l;
  logic [9:0]    r_y_l;
  logic          r_en_l;
  logic [7:0]    r_fill_l;

  logic          r_hit_d1;
  logic          r_hit_d2;
  logic [7:0]    r_fill_d1;
  logic [7:0]    r_fill_d2;

  logic          w_fs;
  logic [11:0]   w_x_end;
  logic [10:0]   w_y_end;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_hit;
  logic [10:0]   w_dx;
  logic [9:0]    w_dy;
  logic [10:0]   w_col;
  logic [9:0]    w_row;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_pix;
  logic          w_pvld;

  assign w_fs = (hcount == 11'd0) && (vcount == 10'd0);

  // End coordinates carry one extra bit so a sprite near the top of the range cannot wrap.
  assign w_x_end = {1'b0, r_x_l} + SW_C;
  assign w_y_end = {1'b0, r_y_l} + SH_C;

  assign w_in_x = (hcount >= r_x_l) && ({1'b0, hcount} < w_x_end) && ({1'b0, hcount} < HA_C);
  assign w_in_y = (vcount >= r_y_l) && ({1'b0, vcount} < w_y_end) && ({1'b0, vcount} < VA_C);
  assign w_hit  = r_en_l && w_in_x && w_in_y;

  assign w_dx   = hcount - r_x_l;
  assign w_dy   = vcount - r_y_l;
  assign w_col  = w_dx >> SCALE_LOG2;
  assign w_row  = w_dy >> SCALE_LOG2;
  assign w_addr = AW'(w_row) * AW'(W) + AW'(w_col);

  // Shadows change only at frame start; the hit test on that same edge still sees the old values.
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      r_x_l    <= 11'(X_INIT);
      r_y_l    <= 10'(Y_INIT);
      r_en_l   <= 1'b0;
      r_fill_l <= 8'h00;
    end else if (w_fs) begin
      r_x_l    <= x_pos;
      r_y_l    <= y_pos;
      r_en_l   <= enable;
      r_fill_l <= fill_color;
    end
  end

  always_comb begin
    w_pix  = 8'h00;
    w_pvld = 1'b0;
    if (r_hit_d2) begin
      case (rom_data)
        2'b00: w_pvld = (TRANSPARENT == 0);
        2'b01: begin
          w_pix  = r_fill_d2;
          w_pvld = 1'b1;
        end
        2'b10: begin
          w_pix  = SHADE;
          w_pvld = 1'b1;
        end
        default: begin
          w_pix  = 8'hFF;
          w_pvld = 1'b1;
        end
      endcase
    end
  end

  // Fill colour travels with the pixel so a frame-start edge never recolours pixels already in flight.
  always_ff @(posedge vclk or negedge rst) begin
    if (!rst) begin
      rom_addr    <= '0;
      r_hit_d1    <= 1'b0;
      r_hit_d2    <= 1'b0;
      r_fill_d1   <= 8'h00;
      r_fill_d2   <= 8'h00;
      pixel_out   <= 8'h00;
      pixel_valid <= 1'b0;
    end else begin
      if (w_hit) begin
        rom_addr <= w_addr;
      end
      r_hit_d1    <= w_hit;
      r_fill_d1   <= r_fill_l;
      r_hit_d2    <= r_hit_d1;
      r_fill_d2   <= r_fill_d1;
      pixel_out   <= w_pix;
      pixel_valid <= w_pvld;
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Self-checking bench: a default 78x53 instance and a 4x2, 2x-scaled, opaque-black instance share one scan.
// A coordinate-level reference model predicts every output; directed tables and sequences pin the corner cases.
module tb_sprite_draw_engine;

  logic        vclk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        enable;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [7:0]  fill_color;

  logic [12:0] rom_addr_a;
  logic [1:0]  rom_data_a;
  logic [7:0]  pixel_out_a;
  logic        pixel_valid_a;
  logic [3:0]  rom_addr_b;
  logic [1:0]  rom_data_b;
  logic [7:0]  pixel_out_b;
  logic        pixel_valid_b;

  logic [1:0]  rom_a [0:8191];
  logic [1:0]  rom_b [0:15];

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_va;
  int cnt_vb;

  int m_x, m_y, m_en, m_fill;
  int ea, eb;

  typedef struct { bit va; int pa; bit vb; int pb; } exp_t;
  exp_t q[$];

  typedef struct { int h; int v; int av; int ap; int aa; int bv; int bp; int ba; } vec_t;
  vec_t tbl[11];

  int exp_r10[8];
  int exp_r12[8];

  sprite_draw_engine u_dut_a (
    .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .enable(enable),
    .x_pos(x_pos), .y_pos(y_pos), .fill_color(fill_color),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .pixel_out(pixel_out_a), .pixel_valid(pixel_valid_a)
  );

  sprite_draw_engine #(.W(4), .H(2), .SCALE_LOG2(1), .AW(4), .TRANSPARENT(0)) u_dut_b (
    .vclk(vclk), .rst(rst), .hcount(hcount), .vcount(vcount), .enable(enable),
    .x_pos(x_pos), .y_pos(y_pos), .fill_color(fill_color),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .pixel_out(pixel_out_b), .pixel_valid(pixel_valid_b)
  );

  initial vclk = 1'b0;
  always #5 vclk = ~vclk;

  always @(posedge vclk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sprite semantics straight from screen geometry: no pipeline, no state encoding.
  function automatic void ref_pixel(input int hc, input int vc, input int w, input int hh, input int s,
                                    input int transp, input bit use_b,
                                    output bit hit, output int idx, output bit vld, output int pix);
    int sc, code;
    sc  = 1 << s;
    hit = (m_en != 0) && hc >= m_x && hc < m_x + w * sc && vc >= m_y && vc < m_y + hh * sc
          && hc < 640 && vc < 480;
    idx = 0; vld = 0; pix = 0;
    if (hit) begin
      idx  = ((vc - m_y) / sc) * w + (hc - m_x) / sc;
      code = use_b ? int'(rom_b[idx]) : int'(rom_a[idx]);
      case (code)
        0: vld = (transp == 0);
        1: begin vld = 1; pix = m_fill; end
        2: begin vld = 1; pix = 'hE0; end
        default: begin vld = 1; pix = 'hFF; end
      endcase
    end
  endfunction

  task automatic model_reset();
    exp_t z;
    m_x = 338; m_y = 485; m_en = 0; m_fill = 0;
    ea = 0; eb = 0;
    z = '{0, 0, 0, 0};
    q.delete();
    q.push_back(z);
    q.push_back(z);
  endtask

  task automatic cycle(input int hc, input int vc);
    exp_t e;
    bit   hit;
    int   idx;
    bit   vld;
    int   pix;
    hcount = 11'(hc);
    vcount = 10'(vc);
    @(posedge vclk);
    ref_pixel(hc, vc, 78, 53, 0, 1, 1'b0, hit, idx, vld, pix);
    if (hit) ea = idx % 8192;
    e.va = vld; e.pa = pix;
    ref_pixel(hc, vc, 4, 2, 1, 0, 1'b1, hit, idx, vld, pix);
    if (hit) eb = idx % 16;
    e.vb = vld; e.pb = pix;
    if (hc == 0 && vc == 0) begin
      m_x = int'(x_pos); m_y = int'(y_pos); m_en = int'(enable); m_fill = int'(fill_color);
    end
    q.push_back(e);
    @(negedge vclk);
    check("a_addr", int'(rom_addr_a), ea);
    check("b_addr", int'(rom_addr_b), eb);
    e = q.pop_front();
    check("a_valid", int'(pixel_valid_a), int'(e.va));
    check("a_pix", int'(pixel_out_a), e.pa);
    check("b_valid", int'(pixel_valid_b), int'(e.vb));
    check("b_pix", int'(pixel_out_b), e.pb);
    if (pixel_valid_a) cnt_va++;
    if (pixel_valid_b) cnt_vb++;
  endtask

  task automatic idle2();
    cycle(700, 10);
    cycle(700, 10);
  endtask

  task automatic sweep(input int h0, input int h1, input int vc);
    for (int h = h0; h <= h1; h++) cycle(h, vc);
  endtask

  initial begin
    int hc, vc;

    tbl[0]  = '{338,  85, 0, 'h00,    0, 1, 'h00, 0};
    tbl[1]  = '{339,  85, 1, 'h1C,    1, 1, 'h00, 0};
    tbl[2]  = '{340,  85, 1, 'hE0,    2, 1, 'h1C, 1};
    tbl[3]  = '{341,  85, 1, 'hFF,    3, 1, 'h1C, 1};
    tbl[4]  = '{415, 137, 1, 'h1C, 4133, 0, 'h00, 1};
    tbl[5]  = '{416, 137, 0, 'h00, 4133, 0, 'h00, 1};
    tbl[6]  = '{345,  88, 1, 'h1C,  241, 1, 'hFF, 7};
    tbl[7]  = '{346,  88, 1, 'hE0,  242, 0, 'h00, 7};
    tbl[8]  = '{342,  87, 0, 'h00,  160, 1, 'hE0, 6};
    tbl[9]  = '{338, 138, 0, 'h00,  160, 0, 'h00, 6};
    tbl[10] = '{344,  86, 0, 'h00,   84, 1, 'hFF, 3};
    exp_r10 = '{0, 0, 1, 1, 2, 2, 3, 3};
    exp_r12 = '{4, 4, 5, 5, 6, 6, 7, 7};

    for (int i = 0; i < 8192; i++) rom_a[i] = 2'(i % 4);
    for (int i = 0; i < 16; i++) rom_b[i] = 2'(i % 4);

    rst = 1'b0;
    hcount = 11'd0; vcount = 10'd0;
    enable = 1'b1; x_pos = 11'd338; y_pos = 10'd85; fill_color = 8'h1C;
    repeat (3) @(posedge vclk);
    @(negedge vclk);
    check("rst_a_pix", int'(pixel_out_a), 0);
    check("rst_a_valid", int'(pixel_valid_a), 0);
    check("rst_a_addr", int'(rom_addr_a), 0);
    check("rst_b_addr", int'(rom_addr_b), 0);
    rst = 1'b1;
    model_reset();

    // Reset shadows: enable low, nothing drawn before the first frame start.
    cnt_va = 0;
    sweep(336, 420, 485);
    cycle(340, 86);
    idle2();
    check("pre_fs_count", cnt_va, 0);

    cycle(0, 0);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].h, tbl[i].v);
      idle2();
      check($sformatf("tbl%0d_a_valid", i), int'(pixel_valid_a), tbl[i].av);
      check($sformatf("tbl%0d_a_pix", i), int'(pixel_out_a), tbl[i].ap);
      check($sformatf("tbl%0d_a_addr", i), int'(rom_addr_a), tbl[i].aa);
      check($sformatf("tbl%0d_b_valid", i), int'(pixel_valid_b), tbl[i].bv);
      check($sformatf("tbl%0d_b_pix", i), int'(pixel_out_b), tbl[i].bp);
      check($sformatf("tbl%0d_b_addr", i), int'(rom_addr_b), tbl[i].ba);
    end

    // Scaled instance at (10,10): 8 x 4 on screen, each texel doubled.
    x_pos = 11'd10; y_pos = 10'd10;
    cycle(0, 0);
    for (int h = 8; h <= 19; h++) begin
      cycle(h, 10);
      if (h >= 10 && h <= 17) check("b_addr_row10", int'(rom_addr_b), exp_r10[h - 10]);
    end
    for (int h = 8; h <= 19; h++) begin
      cycle(h, 12);
      if (h >= 10 && h <= 17) check("b_addr_row12", int'(rom_addr_b), exp_r12[h - 10]);
    end
    cnt_vb = 0;
    sweep(8, 19, 13);
    idle2();
    check("b_row13_count", cnt_vb, 8);
    cnt_vb = 0;
    sweep(8, 19, 14);
    idle2();
    check("b_row14_count", cnt_vb, 0);

    for (int i = 0; i < 8192; i++) rom_a[i] = 2'b11;

    // Right-edge clip: only columns 600..639 of the default sprite, no wrap to column 0.
    x_pos = 11'd600; y_pos = 10'd100;
    cycle(0, 0);
    cnt_va = 0;
    sweep(590, 700, 100);
    sweep(0, 5, 100);
    idle2();
    check("clip_count", cnt_va, 40);

    // Mid-frame x_pos change is ignored until the next frame start.
    x_pos = 11'd338; y_pos = 10'd180;
    cycle(0, 0);
    x_pos = 11'd100;
    cnt_va = 0;
    sweep(95, 180, 200);
    idle2();
    check("midframe_new_x", cnt_va, 0);
    cnt_va = 0;
    sweep(330, 420, 200);
    idle2();
    check("midframe_old_x", cnt_va, 78);
    cycle(0, 0);
    cnt_va = 0;
    sweep(95, 180, 200);
    idle2();
    check("nextframe_new_x", cnt_va, 78);

    // Asynchronous reset in the middle of a drawn line.
    sweep(100, 120, 200);
    check("pre_rst_valid", int'(pixel_valid_a), 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", int'(pixel_valid_a), 0);
    check("async_rst_pix", int'(pixel_out_a), 0);
    check("async_rst_addr", int'(rom_addr_a), 0);
    @(negedge vclk);
    rst = 1'b1;
    model_reset();
    cnt_va = 0;
    sweep(95, 180, 200);
    idle2();
    check("post_rst_nodraw", cnt_va, 0);
    cycle(0, 0);
    cnt_va = 0;
    sweep(95, 180, 200);
    idle2();
    check("post_rst_redraw", cnt_va, 78);

    for (int i = 0; i < 8192; i++) rom_a[i] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 16; i++) rom_b[i] = 2'($urandom_range(0, 3));

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        enable     = ($urandom_range(0, 3) != 0);
        x_pos      = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 650));
        y_pos      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 490));
        fill_color = 8'($urandom_range(0, 255));
        cycle(0, 0);
      end else begin
        if ($urandom_range(0, 19) == 0) begin
          x_pos = 11'($urandom_range(0, 2047));
          y_pos = 10'($urandom_range(0, 1023));
        end
        if ($urandom_range(0, 3) == 0) begin
          hc = int'($urandom_range(0, 2047));
          vc = int'($urandom_range(0, 1023));
        end else begin
          hc = m_x - 5 + int'($urandom_range(0, 320));
          vc = m_y - 3 + int'($urandom_range(0, 60));
          if (hc < 0) hc = 0;
          if (hc > 2047) hc = 2047;
          if (vc < 0) vc = 0;
          if (vc > 1023) vc = 1023;
        end
        cycle(hc, vc);
      end
    end
    idle2();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Parametrised successor to the fixed-position per-piece block drawers: renders one W x H 2-bit-per-pixel sprite from an external synchronous ROM at a runtime-movable screen position, with optional integer pixel scaling, palette mapping and transparency.
- Sits between the VGA timing generator (hcount/vcount) and the pixel mixer.
- One instance replaces the per-block, per-position drawers; the mixer uses pixel_valid to layer sprites.

Parameters:
- W, 78, sprite width in source texels
- H, 53, sprite height in source texels
- SCALE_LOG2, 0, on-screen magnification 2^SCALE_LOG2 (0..2)
- AW, 13, ROM address width; must satisfy 2^AW >= W*H
- X_INIT, 338, x_pos value after reset
- Y_INIT, 485, y_pos value after reset
- H_ACTIVE, 640, visible columns; hcount >= H_ACTIVE is never drawn
- V_ACTIVE, 480, visible rows; must satisfy V_ACTIVE <= 1023
- SHADE, 8'hE0, colour for texel code 2'b10
- TRANSPARENT, 1, 1: code 2'b00 is transparent; 0: code 2'b00 is opaque black

Ports:
- vclk, input, 1, pixel clock
- rst, input, 1, asynchronous active-low reset
- hcount, input, 11, current column from timing generator
- vcount, input, 10, current row from timing generator
- enable, input, 1, sprite shown when 1; sampled at frame start
- x_pos, input, 11, left screen column of sprite; sampled at frame start
- y_pos, input, 10, top screen row of sprite; sampled at frame start
- fill_color, input, 8, colour for texel code 2'b01; sampled at frame start
- rom_addr, output, AW, registered texel address to the sprite ROM
- rom_data, input, 2, texel code; ROM is synchronous, data valid one clock after rom_addr
- pixel_out, output, 8, RGB332 pixel
- pixel_valid, output, 1, 1 = pixel_out is an opaque sprite pixel

Behaviour:
- Reset (rst = 0, asynchronous):
  - pixel_out = 0, pixel_valid = 0, rom_addr = 0.
  - Latched position = X_INIT/Y_INIT; latched enable = 0; latched fill = 0.
  - All pipeline valid bits cleared.
- Frame-start latch:
  - Condition: hcount == 0 and vcount == 0.
  - Registers x_pos, y_pos, enable, fill_color into shadow registers.
  - All drawing uses the shadows only, so there is no tearing mid-frame.
- Hit test (stage 0, combinational on inputs):
  - SW = W << SCALE_LOG2, SH = H << SCALE_LOG2.
  - hit = en_l and hcount in [x_l, x_l + SW) and vcount in [y_l, y_l + SH) and hcount < H_ACTIVE and vcount < V_ACTIVE.
  - Sums are computed one bit wider than the operands, so positions near the maximum never wrap.
- Address:
  - col = (hcount - x_l) >> SCALE_LOG2; row = (vcount - y_l) >> SCALE_LOG2.
  - rom_addr = row * W + col, truncated to AW bits; computed arithmetically, with no running counter.
  - When hit = 0, rom_addr holds its previous value.
- Pipeline, for (hcount, vcount) sampled at edge k:
  - Edge k: rom_addr and hit_d1 registered.
  - Edge k+1: ROM presents rom_data; hit_d2 registered.
  - Edge k+2: pixel_out and pixel_valid registered.
  - Latency is exactly 2 clocks; throughput is 1 pixel/clock.
- Palette, at edge k+2 when hit_d2 = 1:
  - Code 00: TRANSPARENT = 1 gives pixel_valid = 0, pixel_out = 0. TRANSPARENT = 0 gives pixel_valid = 1, pixel_out = 8'h00.
  - Code 01: pixel_out = fill_l, pixel_valid = 1.
  - Code 10: pixel_out = SHADE, pixel_valid = 1.
  - Code 11: pixel_out = 8'hFF, pixel_valid = 1.
- When hit_d2 = 0: pixel_out = 0, pixel_valid = 0.
- Boundary conditions:
  - Sprite extending past H_ACTIVE or V_ACTIVE is clipped, with no wrap to the left edge.
  - x_pos/y_pos changes mid-frame take effect at the next frame start only.
  - Frame start coinciding with a hit: the new shadow values apply from the next edge; pixel (0,0) uses the old values.
  - rst asserted mid-line: outputs drop to 0 immediately. After release, drawing resumes at the next frame start with X_INIT/Y_INIT and enable = 0.
  - enable = 0: pixel_valid stays 0 for the whole frame; rom_addr is static.

Test Plan:
- Reset, then frame start with x_pos = 338, y_pos = 85, enable = 1; ROM filled with code 11:
  - pixel_valid = 1 exactly for hcount 338..415, vcount 85..137.
  - Outputs lag hcount by 2 clocks; the first valid pixel has rom_addr 0, the last has rom_addr 4133.
- ROM texel codes cycle 00/01/10/11; fill_color = 8'h1C; TRANSPARENT = 1:
  - pixel_out sequence 00 (invalid), 1C, E0, FF.
  - Rerun with TRANSPARENT = 0: code 00 gives valid = 1, pixel_out = 00.
- SCALE_LOG2 = 1, W = 4, H = 2, x = 10, y = 10:
  - Drawn region is columns 10..17, rows 10..13.
  - rom_addr row 10 = 0,0,1,1,2,2,3,3; row 12 = 4,4,5,5,...
- x_pos = 600 with W = 78, H_ACTIVE = 640:
  - Valid only for hcount 600..639; nothing at hcount 640..677 and no wrap at hcount 0.
- Change x_pos from 338 to 100 mid-frame at vcount 200:
  - Current frame keeps x = 338; next frame draws at x = 100.
- Assert rst low during an active sprite line:
  - pixel_out = 0 and pixel_valid = 0 without a clock edge.
  - After release, no drawing until frame start with enable = 1 sampled.
